// File: rtl/fp_norm_pkg.sv
// Shared types and default widths for the floating-point mantissa normalizer.
package fp_norm_pkg;
  localparam int DEF_MANT_W = 24;
  localparam int DEF_EXP_W  = 8;
  localparam int CHUNK_W    = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/lopd_8bit.sv
// Leading-one position detector for one byte: pos is the bit index of the highest set bit.
module lopd_8bit (
  input  logic [7:0] data,
  output logic [2:0] pos,
  output logic       zero
);
  always_comb begin
    pos = '0;
    for (int i = 0; i < 8; i++)
      if (data[i]) pos = 3'(i);
    zero = (data == '0);
  end
endmodule

// File: rtl/fp_normalizer.sv
// Iterative mantissa normalizer: shifts up to one byte per cycle, clamping at the subnormal boundary.
module fp_normalizer
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = DEF_MANT_W,
  parameter int EXP_W  = DEF_EXP_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [MANT_W-1:0]         i_mant,
  input  logic [EXP_W-1:0]          i_exp,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [MANT_W-1:0]         o_mant,
  output logic [EXP_W-1:0]          o_exp,
  output logic [$clog2(MANT_W):0]   o_shamt,
  output logic                      o_zero,
  output logic                      o_denorm
);
  localparam int SH_W = $clog2(MANT_W) + 1;

  state_t             state, state_nx;
  logic [MANT_W-1:0]  mant_q, mant_nx;
  logic [EXP_W-1:0]   exp_q, exp_nx, exp_m1;
  logic [SH_W-1:0]    shamt_q, shamt_nx;
  logic               zero_q, zero_nx, denorm_q, denorm_nx;

  logic [2:0]         lead_pos;
  logic               top_zero, clamp;
  logic [3:0]         s, sh;
  logic [EXP_W+3:0]   s_ext, lim_ext;

  lopd_8bit u_lopd (
    .data (mant_q[MANT_W-1 -: CHUNK_W]),
    .pos  (lead_pos),
    .zero (top_zero)
  );

  // Compare s against exp-1 in a widened domain so neither side truncates.
  always_comb begin
    s       = top_zero ? 4'd8 : (4'd7 - {1'b0, lead_pos});
    exp_m1  = exp_q - EXP_W'(1);
    s_ext   = (EXP_W+4)'(s);
    lim_ext = {4'b0, exp_m1};
    clamp   = (s_ext > lim_ext);
    sh      = clamp ? lim_ext[3:0] : s;
  end

  always_comb begin
    state_nx  = state;
    mant_nx   = mant_q;
    exp_nx    = exp_q;
    shamt_nx  = shamt_q;
    zero_nx   = zero_q;
    denorm_nx = denorm_q;
    case (state)
      IDLE: if (i_valid) begin
        mant_nx   = i_mant;
        exp_nx    = i_exp;
        shamt_nx  = '0;
        zero_nx   = 1'b0;
        denorm_nx = 1'b0;
        if (i_mant == '0) begin
          exp_nx   = '0;
          zero_nx  = 1'b1;
          state_nx = DONE;
        end else if (i_exp == '0) begin
          denorm_nx = 1'b1;
          state_nx  = DONE;
        end else begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        mant_nx  = mant_q << sh;
        shamt_nx = shamt_q + SH_W'(sh);
        if (clamp) begin
          exp_nx    = '0;
          denorm_nx = 1'b1;
          state_nx  = DONE;
        end else begin
          exp_nx = exp_q - EXP_W'(s);
          if (!top_zero) state_nx = DONE;
        end
      end
      DONE: if (i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      shamt_q  <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
    end else begin
      state    <= state_nx;
      mant_q   <= mant_nx;
      exp_q    <= exp_nx;
      shamt_q  <= shamt_nx;
      zero_q   <= zero_nx;
      denorm_q <= denorm_nx;
    end
  end

  assign o_ready  = (state == IDLE);
  assign o_valid  = (state == DONE);
  assign o_mant   = mant_q;
  assign o_exp    = exp_q;
  assign o_shamt  = shamt_q;
  assign o_zero   = zero_q;
  assign o_denorm = denorm_q;
endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: directed corner cases plus randomized operands vs. a reference model.
module tb_fp_normalizer;
  logic        i_clk = 1'b0;
  logic        i_rst_n, i_valid, i_ready;
  logic        o_ready, o_valid, o_zero, o_denorm;
  logic [23:0] i_mant, o_mant;
  logic [7:0]  i_exp, o_exp;
  logic [5:0]  o_shamt;

  int n_cmp = 0;
  int n_bad = 0;

  fp_normalizer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_mant(i_mant), .i_exp(i_exp), .o_valid(o_valid), .i_ready(i_ready),
    .o_mant(o_mant), .o_exp(o_exp), .o_shamt(o_shamt),
    .o_zero(o_zero), .o_denorm(o_denorm)
  );

  always #5 i_clk = ~i_clk;

  // Reference: normalize by the full leading-zero count, bounded by exp-1.
  // Latency counts edges from accept to o_valid: one, plus the byte-sized shift cycles.
  task automatic model(input logic [23:0] m, input logic [7:0] e,
                       output logic [23:0] em, output logic [7:0] ee, output logic [5:0] es,
                       output logic ez, output logic ed, output int lat);
    int lz, ei, full;
    ei = int'(e);
    if (m == 24'd0) begin
      em = 0; ee = 0; es = 0; ez = 1; ed = 0; lat = 1;
    end else if (ei == 0) begin
      em = m; ee = 0; es = 0; ez = 0; ed = 1; lat = 1;
    end else begin
      lz = 0;
      while (m[23-lz] == 1'b0) lz++;
      ez = 0;
      if (lz <= ei - 1) begin
        em = m << lz; ee = 8'(ei - lz); es = 6'(lz); ed = 0;
      end else begin
        em = m << (ei - 1); ee = 0; es = 6'(ei - 1); ed = 1;
      end
      full = (lz / 8 < (ei - 1) / 8) ? lz / 8 : (ei - 1) / 8;
      lat = 2 + full;
    end
  endtask

  task automatic run_op(input logic [23:0] m, input logic [7:0] e,
                        output logic [23:0] rm, output logic [7:0] re, output logic [5:0] rs,
                        output logic rz, output logic rd, output int lat);
    int guard;
    guard = 0;
    @(negedge i_clk);
    while (o_ready !== 1'b1 && guard < 20) begin @(negedge i_clk); guard++; end
    i_valid = 1'b1; i_mant = m; i_exp = e; i_ready = 1'b0;
    @(negedge i_clk);
    // Junk on the inputs while busy must be ignored.
    i_valid = 1'($urandom_range(0, 1)); i_mant = 24'($urandom); i_exp = 8'($urandom);
    lat = 1;
    while (o_valid !== 1'b1 && lat < 20) begin @(negedge i_clk); lat++; end
    rm = o_mant; re = o_exp; rs = o_shamt; rz = o_zero; rd = o_denorm;
  endtask

  // Handshake with an operand offered in the same cycle; it must not be taken.
  task automatic finish_op();
    i_ready = 1'b1; i_valid = 1'b1; i_mant = 24'h000123; i_exp = 8'd50;
    @(negedge i_clk);
    i_ready = 1'b0; i_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 0; i_ready = 0; i_mant = 0; i_exp = 0;
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if ({o_ready, o_valid, o_mant, o_exp, o_shamt, o_zero, o_denorm} !== {1'b1, 1'b0, 24'd0, 8'd0, 6'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_vals: got rdy=%b vld=%b m=%h e=%0d sh=%0d z=%b d=%b want rdy=1 vld=0 all zero",
               o_ready, o_valid, o_mant, o_exp, o_shamt, o_zero, o_denorm);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_directed();
    logic [23:0] tm [4] = '{24'h800000, 24'h000123, 24'h000001, 24'h000000};
    logic [7:0]  te [4] = '{8'd100, 8'd100, 8'd5, 8'd77};
    logic [23:0] xm [4] = '{24'h800000, 24'h918000, 24'h000010, 24'h000000};
    logic [7:0]  xe [4] = '{8'd100, 8'd85, 8'd0, 8'd0};
    logic [5:0]  xs [4] = '{6'd0, 6'd15, 6'd4, 6'd0};
    logic        xz [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        xd [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int          xl [4] = '{2, 3, 2, 1};
    logic [23:0] rm; logic [7:0] re; logic [5:0] rs; logic rz, rd; int lat;
    for (int k = 0; k < 4; k++) begin
      run_op(tm[k], te[k], rm, re, rs, rz, rd, lat);
      n_cmp++;
      if ({rm, re, rs, rz, rd} !== {xm[k], xe[k], xs[k], xz[k], xd[k]}) begin
        n_bad++;
        $display("FAIL dir_result[%0d]: got m=%h e=%0d sh=%0d z=%b d=%b want m=%h e=%0d sh=%0d z=%b d=%b",
                 k, rm, re, rs, rz, rd, xm[k], xe[k], xs[k], xz[k], xd[k]);
      end
      n_cmp++;
      if (lat != xl[k]) begin
        n_bad++;
        $display("FAIL dir_latency[%0d]: got %0d want %0d", k, lat, xl[k]);
      end
      finish_op();
      n_cmp++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL dir_release[%0d]: got rdy=%b vld=%b want rdy=1 vld=0", k, o_ready, o_valid);
      end
    end
  endtask

  task automatic test_stall();
    logic [23:0] rm; logic [7:0] re; logic [5:0] rs; logic rz, rd; int lat;
    run_op(24'h000123, 8'd100, rm, re, rs, rz, rd, lat);
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b1; i_mant = 24'($urandom); i_exp = 8'($urandom);
      @(negedge i_clk);
      n_cmp++;
      if ({o_valid, o_ready, o_mant, o_exp, o_shamt, o_zero, o_denorm} !==
          {1'b1, 1'b0, 24'h918000, 8'd85, 6'd15, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got vld=%b rdy=%b m=%h e=%0d sh=%0d want vld=1 rdy=0 m=918000 e=85 sh=15",
                 c, o_valid, o_ready, o_mant, o_exp, o_shamt);
      end
    end
    finish_op();
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    @(negedge i_clk);
    i_valid = 1'b1; i_mant = 24'h000123; i_exp = 8'd100; i_ready = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b0;
    n_cmp++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_busy: got rdy=%b vld=%b want rdy=0 vld=0", o_ready, o_valid);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_ready, o_valid, o_mant, o_exp, o_shamt, o_zero, o_denorm} !== {1'b1, 1'b0, 24'd0, 8'd0, 6'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_async: got rdy=%b vld=%b m=%h e=%0d sh=%0d want reset values",
               o_ready, o_valid, o_mant, o_exp, o_shamt);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge i_clk);
      if (o_valid !== 1'b0 || o_ready !== 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL rst_discard: got %0d non-idle cycles want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [23:0] m, rm, em; logic [7:0] e, re, ee; logic [5:0] rs, es;
    logic rz, rd, ez, ed; int lat, elat, errs;
    errs = 0;
    for (int k = 0; k < 80; k++) begin
      m = ($urandom_range(0, 9) == 0) ? 24'd0 : 24'($urandom >> $urandom_range(8, 31));
      e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
      model(m, e, em, ee, es, ez, ed, elat);
      run_op(m, e, rm, re, rs, rz, rd, lat);
      n_cmp++;
      if ({rm, re, rs, rz, rd} !== {em, ee, es, ez, ed} || lat != elat) begin
        n_bad++; errs++;
        if (errs < 10)
          $display("FAIL rand[%0d] in m=%h e=%0d: got m=%h e=%0d sh=%0d z=%b d=%b lat=%0d want m=%h e=%0d sh=%0d z=%b d=%b lat=%0d",
                   k, m, e, rm, re, rs, rz, rd, lat, em, ee, es, ez, ed, elat);
      end
      finish_op();
      n_cmp++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_release[%0d]: got rdy=%b vld=%b want rdy=1 vld=0", k, o_ready, o_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_shift();
    test_directed();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
